serial_alu: RTL and testbench

SERIAL_ALU -- requirements
Module: serial_alu

---
 rtl/serial_alu.sv | 118 +++++++++++
 tb/tb_serial_alu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_alu.sv
// Bit-serial ALU: a single 1-bit slice walks the operands LSB first, one bit per clock.
// A start in IDLE captures the operands; done pulses for one cycle once bit N-1 is written.
module serial_alu #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         arit,
   input  logic [1:0]   s,
   input  logic         c_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         c_out
);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [N-1:0]     a_q;
   logic [N-1:0]     b_q;
   logic             arit_q;
   logic [1:0]       s_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             step;
   logic             slice_res;
   logic             slice_carry;

   // Returns {carry, result} for one bit position.
   function automatic logic [1:0] alu_slice(input logic ab, input logic bb, input logic cb,
                                            input logic ar, input logic [1:0] sel);
      logic r;
      logic c;
      c = 1'b0;
      if (ar) begin
         r = ab ^ bb ^ cb;
         c = (ab & bb) | (cb & (ab ^ bb));
      end else begin
         case (sel)
            2'b00:   r = ab & bb;
            2'b01:   r = ab | bb;
            2'b10:   r = ab ^ bb;
            default: r = ~ab;
         endcase
      end
      return {c, r};
   endfunction

   assign {slice_carry, slice_res} = alu_slice(a_q[cnt_q], b_q[cnt_q], carry_q, arit_q, s_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt_q == LAST_BIT) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand copies need no reset: they are only consulted in RUN, which always follows a capture.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q    <= a;
         b_q    <= b;
         arit_q <= arit;
         s_q    <= s;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
         result  <= '0;
         c_out   <= 1'b0;
      end else if (accept) begin
         cnt_q   <= '0;
         carry_q <= c_in;
         result  <= '0;
         c_out   <= 1'b0;
      end else if (step) begin
         result[cnt_q] <= slice_res;
         if (arit_q) carry_q <= slice_carry;
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == LAST_BIT) c_out <= arit_q & slice_carry;
      end
   end
endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu (N=8): inputs driven and outputs sampled on the falling edge.
module tb_serial_alu;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         arit;
   logic [1:0]   s;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         c_out;

   int tests  = 0;
   int failed = 0;
   int cnt_done;
   int cnt_busy;

   always #5 clk = ~clk;

   serial_alu #(.N(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .arit   (arit),
      .s      (s),
      .c_in   (c_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .c_out  (c_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full operation with latency checks; operands are scrambled right after acceptance.
   task automatic run_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_,
                         input logic tar, input logic [1:0] ts, input logic tc,
                         input logic [N-1:0] er, input logic ec);
      @(negedge clk);
      a = ta; b = tb_; arit = tar; s = ts; c_in = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~ta; b = ~tb_; arit = ~tar; s = ~ts; c_in = ~tc;
      check({tag, "_busy_k"}, busy, 1);
      for (int i = 1; i < N; i++) begin
         @(negedge clk);
         check({tag, "_run_done"}, done, 0);
         check({tag, "_run_busy"}, busy, 1);
      end
      @(negedge clk);
      check({tag, "_done"}, done, 1);
      check({tag, "_done_busy"}, busy, 0);
      check({tag, "_result"}, result, er);
      check({tag, "_c_out"}, c_out, ec);
      @(negedge clk);
      check({tag, "_done_low"}, done, 0);
      check({tag, "_result_hold"}, result, er);
      check({tag, "_c_out_hold"}, c_out, ec);
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; a = 8'h01; b = 8'h02; arit = 1'b1; s = 2'b00; c_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_c_out", c_out, 0);

      // start held through reset is taken on the first edge after release
      reset = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("first_accept_busy", busy, 1);
      repeat (7) @(negedge clk);
      check("first_nodone", done, 0);
      @(negedge clk);
      check("first_done", done, 1);
      check("first_result", result, 8'h03);

      run_op("add_3c_05", 8'h3C, 8'h05, 1'b1, 2'b00, 1'b0, 8'h41, 1'b0);
      run_op("add_7f_cin", 8'h7F, 8'h00, 1'b1, 2'b00, 1'b1, 8'h80, 1'b0);
      run_op("and", 8'hA5, 8'h0F, 1'b0, 2'b00, 1'b1, 8'h05, 1'b0);
      run_op("or", 8'hA5, 8'h0F, 1'b0, 2'b01, 1'b1, 8'hAF, 1'b0);
      run_op("xor", 8'hA5, 8'h0F, 1'b0, 2'b10, 1'b1, 8'hAA, 1'b0);
      run_op("not_a", 8'hA5, 8'h0F, 1'b0, 2'b11, 1'b1, 8'h5A, 1'b0);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1);

      // reset in IDLE clears held carry without a clock edge
      #2 reset = 1'b1;
      #1 check("idle_rst_c_out", c_out, 0);
      @(negedge clk);
      reset = 1'b0;

      // start pulsed while bit 3 is in flight is ignored
      @(negedge clk);
      a = 8'h10; b = 8'h20; arit = 1'b1; s = 2'b00; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      a = 8'hF0; b = 8'h0F; arit = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ign_busy", busy, 1);
      repeat (3) @(negedge clk);
      check("ign_nodone", done, 0);
      @(negedge clk);
      check("ign_done", done, 1);
      check("ign_result", result, 8'h30);
      check("ign_c_out", c_out, 0);
      cnt_done = 0; cnt_busy = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) cnt_done++;
         if (busy) cnt_busy++;
      end
      check("ign_no_second_done", cnt_done, 0);
      check("ign_no_second_busy", cnt_busy, 0);

      // asynchronous reset mid-RUN
      @(negedge clk);
      a = 8'hFF; b = 8'h00; arit = 1'b1; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_partial", result, 8'h0F);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_result", result, 0);
      check("abort_c_out", c_out, 0);
      check("abort_done", done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cnt_done = 0; cnt_busy = 0;
      repeat (N + 3) begin
         @(negedge clk);
         if (done) cnt_done++;
         if (busy) cnt_busy++;
      end
      check("abort_no_done", cnt_done, 0);
      check("abort_no_busy", cnt_busy, 0);
      run_op("after_abort", 8'h01, 8'h01, 1'b1, 2'b00, 1'b0, 8'h02, 1'b0);

      // start held high: one operation every N+2 cycles
      @(negedge clk);
      a = 8'h11; b = 8'h22; arit = 1'b1; s = 2'b00; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      check("b2b_busy1", busy, 1);
      a = 8'h40; b = 8'h02;
      repeat (7) @(negedge clk);
      check("b2b_nodone1", done, 0);
      @(negedge clk);
      check("b2b_done1", done, 1);
      check("b2b_result1", result, 8'h33);
      @(negedge clk);
      check("b2b_idle_done", done, 0);
      check("b2b_idle_busy", busy, 0);
      @(negedge clk);
      check("b2b_busy2", busy, 1);
      a = 8'h01; b = 8'h01;
      repeat (7) @(negedge clk);
      check("b2b_nodone2", done, 0);
      @(negedge clk);
      check("b2b_done2", done, 1);
      check("b2b_result2", result, 8'h42);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("b2b_end_done", done, 0);
      check("b2b_end_busy", busy, 0);
      check("b2b_end_hold", result, 8'h42);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
